// File: rtl/sw_btn_dev_io_pkg.sv
// rtl/sw_btn_dev_io_pkg.sv - shared GPIO field layout, widths and status-word packing
//
// Purpose: single home for the register field positions and input widths used by
//          the switch/button device and its bus interface.
// Contents:
//   SW_W / BTN_W        : slide-switch and push-button counts
//   IN_W                : total debounced input count (switches then buttons)
//   SW_LSB              : read-word position of the 16 debounced switches
//   BTN_LVL_LSB         : read-word position of the 4 debounced button levels
//   BTN_PRESS_LSB       : read-word position of the sticky press flags, and the
//                         write-1-to-clear position in the control write
//   IRQ_EN_BIT          : control-write bit that loads the interrupt enable
//   pack_status()       : builds the 32-bit read word from flags/levels/switches
package sw_btn_dev_io_pkg;

    localparam int SW_W          = 16;
    localparam int BTN_W         = 4;
    localparam int IN_W          = SW_W + BTN_W;

    localparam int SW_LSB        = 0;
    localparam int BTN_LVL_LSB   = 24;
    localparam int BTN_PRESS_LSB = 28;
    localparam int IRQ_EN_BIT    = 0;

    // Bits 23:16 of the read word are reserved and always read as zero.
    function automatic logic [31:0] pack_status(
        input logic [BTN_W-1:0] press,
        input logic [BTN_W-1:0] lvl,
        input logic [SW_W-1:0]  sw
    );
        logic [31:0] word;
        word = '0;
        word[BTN_PRESS_LSB +: BTN_W] = press;
        word[BTN_LVL_LSB +: BTN_W]   = lvl;
        word[SW_LSB +: SW_W]         = sw;
        return word;
    endfunction

endpackage

// File: rtl/sw_btn_dev_io_if.sv
// rtl/sw_btn_dev_io_if.sv - CPU-side GPIO register bus for the switch/button device
//
// Purpose: groups the CPU strobes, write data, read data and interrupt line.
// Signals:
//   GPIOe0000000_re : read strobe for the input-device register (CPU -> device)
//   GPIOe0000000_we : write strobe for the control/clear register (CPU -> device)
//   peripheral_in   : 32-bit write data (CPU -> device)
//   peripheral_out  : 32-bit registered read data (device -> CPU)
//   btn_irq         : level interrupt request (device -> CPU)
// Modports: master = CPU side, slave = device side.
interface sw_btn_dev_io_if;

    logic        GPIOe0000000_re;
    logic        GPIOe0000000_we;
    logic [31:0] peripheral_in;
    logic [31:0] peripheral_out;
    logic        btn_irq;

    modport master (
        output GPIOe0000000_re,
        output GPIOe0000000_we,
        output peripheral_in,
        input  peripheral_out,
        input  btn_irq
    );

    modport slave (
        input  GPIOe0000000_re,
        input  GPIOe0000000_we,
        input  peripheral_in,
        output peripheral_out,
        output btn_irq
    );

endinterface

// File: rtl/sw_btn_dev_io_debounce_bit.sv
// rtl/sw_btn_dev_io_debounce_bit.sv - two-flop synchronizer plus counter debouncer for one pin
//
// Purpose: brings one raw asynchronous pin into the clk domain and accepts a new
//          level only after DEB_CYCLES consecutive synchronized samples disagree
//          with the current debounced level.
// Parameters:
//   DEB_CYCLES : consecutive differing samples needed to accept a change (2..65535)
// Ports:
//   clk  : clock, falling-edge active
//   rst  : asynchronous active-high reset
//   din  : raw asynchronous pin
//   db   : debounced level
//   rise : one-cycle-early indication that db goes 0->1 on the coming edge
module debounce_bit #(
    parameter int DEB_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic db,
    output logic rise
);

    localparam logic [15:0] CNT_LAST = 16'(DEB_CYCLES - 1);

    logic        sync1;
    logic        sync2;
    logic [15:0] cnt;
    logic        differ;
    logic        accept;

    assign differ = (sync2 != db);
    // The counter sits at DEB_CYCLES-1 after that many differing samples; one
    // more differing sample makes the change final.
    assign accept = differ && (cnt == CNT_LAST);
    // Combinational so the press flag sets on the same edge db rises.
    assign rise   = accept && sync2;

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            db    <= 1'b0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            if (!differ) begin
                cnt <= '0;
            end else if (accept) begin
                cnt <= '0;
                db  <= sync2;
            end else begin
                cnt <= cnt + 16'd1;
            end
        end
    end

endmodule

// File: rtl/sw_btn_dev_io.sv
// rtl/sw_btn_dev_io.sv - debounced slide-switch and push-button GPIO device with press interrupt
//
// Purpose: debounces 16 switches and 4 buttons, keeps sticky per-button press
//          flags, and exposes them on a CPU read/write register pair.
// Parameters:
//   DEB_CYCLES : consecutive differing samples needed to accept a change (2..65535)
// Ports:
//   clk    : clock, all registers update on the falling edge
//   rst    : asynchronous active-high reset
//   bus    : CPU register bus (slave side): read/write strobes, write data,
//            registered read data, level interrupt
//   sw_in  : 16 raw slide-switch pins
//   btn_in : 4 raw push-button pins, active-high
// Read word : {btn_press[3:0], btn_db[3:0], 8'h00, sw_db[15:0]}
// Write word: bit 0 loads irq_en, bits 31:28 are write-1-to-clear for btn_press
module sw_btn_dev_io
    import sw_btn_dev_io_pkg::*;
#(
    parameter int DEB_CYCLES = 50000
) (
    input  logic                clk,
    input  logic                rst,
    sw_btn_dev_io_if.slave      bus,
    input  logic [SW_W-1:0]     sw_in,
    input  logic [BTN_W-1:0]    btn_in
);

    logic [IN_W-1:0]  raw;
    logic [IN_W-1:0]  db;
    logic [IN_W-1:0]  rise;

    logic [BTN_W-1:0] btn_press;
    logic [BTN_W-1:0] btn_press_next;
    logic             irq_en;
    logic             irq_q;
    logic [31:0]      out_q;

    logic [SW_W-1:0]  sw_db;
    logic [BTN_W-1:0] btn_db;
    logic [BTN_W-1:0] btn_rise;
    logic [BTN_W-1:0] clr_mask;

    // Switches occupy the low input indices, buttons the high ones.
    assign raw = {btn_in, sw_in};

    for (genvar i = 0; i < IN_W; i++) begin : g_deb
        debounce_bit #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_deb (
            .clk  (clk),
            .rst  (rst),
            .din  (raw[i]),
            .db   (db[i]),
            .rise (rise[i])
        );
    end

    assign sw_db    = db[SW_W-1:0];
    assign btn_db   = db[IN_W-1:SW_W];
    assign btn_rise = rise[IN_W-1:SW_W];
    assign clr_mask = bus.peripheral_in[BTN_PRESS_LSB +: BTN_W];

    // Switch rise indications and the unused write-data bits have no consumer.
    logic unused_bits;
    assign unused_bits = ^{rise[SW_W-1:0], bus.peripheral_in[BTN_PRESS_LSB-1:IRQ_EN_BIT+1]};

    // Clear first, then OR in new presses so a press landing on the clear
    // cycle survives.
    always_comb begin
        btn_press_next = btn_press;
        if (bus.GPIOe0000000_we) begin
            btn_press_next = btn_press & ~clr_mask;
        end
        btn_press_next = btn_press_next | btn_rise;
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            btn_press <= '0;
            irq_en    <= 1'b0;
            irq_q     <= 1'b0;
            out_q     <= '0;
        end else begin
            btn_press <= btn_press_next;
            if (bus.GPIOe0000000_we) begin
                irq_en <= bus.peripheral_in[IRQ_EN_BIT];
            end
            irq_q <= irq_en & (|btn_press);
            // Read captures the current (pre-clear) flags; a concurrent write
            // clears them only for subsequent reads.
            if (bus.GPIOe0000000_re) begin
                out_q <= pack_status(btn_press, btn_db, sw_db);
            end
        end
    end

    assign bus.peripheral_out = out_q;
    assign bus.btn_irq        = irq_q;

endmodule
